uart_controller: RTL and testbench

- Memory-mapped UART controller between the CPU data bus (Wishbone slave) and the async_transmitter/async_receiver pair.
- Sequences the transmitter start/busy handshake and the receiver ready/clear handshake.
- Buffers received bytes in a small FIFO and exposes a 16550-style data/status register pair to software.
- The transmitter and receiver run on clk_i; there is no clock-domain crossing inside this block.

---
 rtl/uart_ctrl_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_controller.sv | 166 ++++++++++++++++
 tb/tb_uart_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
//   Types and constants shared by the UART controller and its receive FIFO.
//   - tx_state_t / rx_state_t : handshake sequencer states
//   - STAT_*                  : bit positions inside the status byte
//   - lane_place()            : moves a byte onto its Wishbone byte lane
package uart_ctrl_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_CLEAR, RX_WAIT} rx_state_t;

  localparam int STAT_DR   = 0;  // receive FIFO holds data
  localparam int STAT_OE   = 1;  // sticky overrun
  localparam int STAT_THRE = 5;  // transmit hold register empty
  localparam int STAT_TEMT = 6;  // hold empty and transmitter fully idle

  function automatic logic [31:0] lane_place(input logic [7:0] b, input logic [1:0] lane);
    return 32'(b) << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Synchronous byte FIFO with a combinational head.
//   clk_i/rst_i : clock, synchronous active-high reset
//   push_i/data_i : write request and byte (accepted when not full, or when
//                   a pop frees the slot in the same cycle)
//   pop_i        : remove head (ignored when empty)
//   head_o, empty_o, full_o, count_o : FIFO state
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // When full, a simultaneous pop vacates the slot the push will overwrite;
  // the head is read combinationally before that edge.
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;  // power-of-two depth wraps naturally
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q decides which entries are valid, so
  // stale contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_controller.sv
// uart_controller
//   Wishbone slave exposing a 16550-style data/status pair in front of an
//   async_transmitter / async_receiver pair, all on clk_i.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   wb_*                    : Wishbone slave (3-bit byte address, 32-bit data)
//   tx_start_o, tx_data_o   : start pulse and byte to the transmitter
//   tx_busy_i               : transmitter busy
//   rx_ready_i, rx_data_i   : receiver byte-ready and byte
//   rx_clear_o              : one-cycle acknowledge back to the receiver
module uart_controller
  import uart_ctrl_pkg::*;
#(
  parameter int         RX_FIFO_DEPTH = 4,
  parameter logic [2:0] ADDR_DATA     = 3'h0,
  parameter logic [2:0] ADDR_STATUS   = 3'h5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_busy_i,
  input  logic        rx_ready_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_clear_o
);

  localparam int CW = $clog2(RX_FIFO_DEPTH) + 1;

  logic        ack_q, overrun_q, hold_valid_q, tx_start_q, rx_clear_q;
  logic [31:0] dat_q;
  logic [7:0]  hold_q, tx_data_q;
  tx_state_t   tx_state_q;
  rx_state_t   rx_state_q;

  logic          req, wr_data, tx_load, accept, rd_data, rd_status;
  logic          rx_push, rx_drop;
  logic          fifo_empty, fifo_full;
  logic [7:0]    fifo_head, status_byte, rd_byte;
  logic [CW-1:0] fifo_count;

  // ---------------- bus decode ----------------
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_data   = req & wb_we_i & (wb_adr_i == ADDR_DATA) & wb_sel_i[0];
  assign tx_load   = wr_data & ~hold_valid_q;
  // A data write while the hold register is occupied waits, un-acked.
  assign accept    = req & ~(wr_data & hold_valid_q);
  assign rd_data   = accept & ~wb_we_i & (wb_adr_i == ADDR_DATA);
  assign rd_status = accept & ~wb_we_i & (wb_adr_i == ADDR_STATUS);

  assign rx_push = (rx_state_q == RX_IDLE) & rx_ready_i;
  // A pop on a full FIFO makes room, so only an unmatched push is lost.
  assign rx_drop = rx_push & fifo_full & ~rd_data;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    status_byte            = '0;
    status_byte[STAT_DR]   = ~fifo_empty;
    status_byte[STAT_OE]   = overrun_q;
    status_byte[STAT_THRE] = ~hold_valid_q;
    status_byte[STAT_TEMT] = ~hold_valid_q & (tx_state_q == TX_IDLE) & ~tx_busy_i;
  end

  always_comb begin
    rd_byte = '0;
    if (rd_data && !fifo_empty) rd_byte = fifo_head;
    else if (rd_status)         rd_byte = status_byte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= accept ? lane_place(rd_byte, wb_adr_i[1:0]) : '0;
      // A drop in the same cycle as a status read wins; the read still
      // reports the value from before this edge.
      if (rx_drop)        overrun_q <= 1'b1;
      else if (rd_status) overrun_q <= 1'b0;
    end
  end

  // ---------------- transmit sequencer ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q   <= TX_IDLE;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      if (tx_load) begin
        hold_q       <= wb_dat_i[7:0];
        hold_valid_q <= 1'b1;
      end
      case (tx_state_q)
        TX_IDLE: if (hold_valid_q) begin
          tx_data_q    <= hold_q;
          tx_start_q   <= 1'b1;
          hold_valid_q <= 1'b0;
          tx_state_q   <= TX_START;
        end
        TX_START: begin
          tx_start_q <= 1'b0;
          tx_state_q <= TX_WAIT;
        end
        TX_WAIT: if (!tx_busy_i) tx_state_q <= TX_IDLE;
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receive sequencer ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_clear_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (rx_ready_i) begin
          rx_clear_q <= 1'b1;
          rx_state_q <= RX_CLEAR;
        end
        RX_CLEAR: begin
          rx_clear_q <= 1'b0;
          rx_state_q <= RX_WAIT;
        end
        RX_WAIT: if (!rx_ready_i) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .data_i  (rx_data_i),
    .pop_i   (rd_data),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Bits that are part of the bus/FIFO interface but carry nothing here.
  logic unused_bits;
  assign unused_bits = &{wb_sel_i[3:1], wb_dat_i[31:8], fifo_count};

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign rx_clear_o = rx_clear_q;

endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller
//   Scoreboard bench: stimulus tasks queue expected read data and expected
//   transmitted bytes; negedge monitors pop and compare as the DUT produces
//   acks and start pulses. A small transmitter model drives tx_busy_i.
module tb_uart_controller;
  import uart_ctrl_pkg::*;

  localparam int         BUSY_LEN = 12;
  localparam logic [2:0] A_DATA   = 3'h0;
  localparam logic [2:0] A_STAT   = 3'h5;
  localparam logic [7:0] IDLE_ST  = 8'h60;  // THRE | TEMT

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [2:0]  wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, tx_start_o, rx_clear_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i = 1'b0;
  logic        rx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = '0;

  always #5 clk_i = ~clk_i;

  uart_controller dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .tx_busy_i  (tx_busy_i),
    .rx_ready_i (rx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_clear_o (rx_clear_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    string       name;
  } rd_exp_t;

  rd_exp_t    exp_rd[$];
  logic [7:0] exp_tx[$];
  int         exp_clear = 0;
  int         clear_cnt = 0;
  logic       clear_prev = 1'b0;
  logic       start_prev = 1'b0;
  rd_exp_t    mon_e;

  // ---------------- monitors ----------------
  always @(negedge clk_i) begin
    if (wb_ack_o === 1'b1 && !wb_we_i) begin
      if (exp_rd.size() == 0) check("unexpected_read_ack", 32'(exp_rd.size()), 1);
      else begin
        mon_e = exp_rd.pop_front();
        check(mon_e.name, wb_dat_o, mon_e.data);
      end
    end
    if (tx_start_o === 1'b1) begin
      check("tx_start_width", 32'(start_prev), 0);
      if (exp_tx.size() == 0) check("unexpected_tx_start", 32'(exp_tx.size()), 1);
      else check("tx_data", 32'(tx_data_o), 32'(exp_tx.pop_front()));
    end
    if (rx_clear_o === 1'b1) begin
      check("rx_clear_width", 32'(clear_prev), 0);
      clear_cnt++;
    end
    start_prev = (tx_start_o === 1'b1);
    clear_prev = (rx_clear_o === 1'b1);
  end

  // ---------------- transmitter model ----------------
  always begin
    @(posedge clk_i); #1;
    if (tx_start_o === 1'b1) begin
      tx_busy_i = 1'b1;
      repeat (BUSY_LEN) @(posedge clk_i);
      #1 tx_busy_i = 1'b0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic wb_xfer(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int cyc);
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    cyc = 0;
    do begin
      @(posedge clk_i); #1;
      cyc++;
    end while (wb_ack_o !== 1'b1 && cyc < 200);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    if (wb_ack_o !== 1'b1) check("bus_ack_timeout", 32'(wb_ack_o), 1);
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [3:0] sel,
                          input logic [7:0] b, output int cyc);
    wb_xfer(1'b1, adr, sel, {24'h0, b}, cyc);
  endtask

  task automatic wb_read(input logic [2:0] adr, input logic [31:0] exp, input string name);
    rd_exp_t e;
    int      c;
    e.data = exp;
    e.name = name;
    exp_rd.push_back(e);
    wb_xfer(1'b0, adr, 4'hF, 32'h0, c);
  endtask

  task automatic rd_status(input logic [7:0] s, input string name);
    wb_read(A_STAT, lane_place(s, A_STAT[1:0]), name);
  endtask

  task automatic rd_data(input logic [7:0] b, input string name);
    wb_read(A_DATA, lane_place(b, A_DATA[1:0]), name);
  endtask

  task automatic rx_deliver(input logic [7:0] b);
    int n;
    @(posedge clk_i); #1;
    rx_data_i = b; rx_ready_i = 1'b1;
    exp_clear++;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (rx_clear_o !== 1'b1 && n < 50);
    check("rx_clear_seen", 32'(rx_clear_o), 1);
    rx_ready_i = 1'b0;
    @(posedge clk_i); #1;  // let the sequencer see ready low before the next byte
  endtask

  task automatic wait_tx_drained();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || tx_busy_i) && n < 1000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("tx_drain", 32'(exp_tx.size() == 0 && !tx_busy_i), 1);
    repeat (2) @(posedge clk_i);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},      32'(wb_ack_o),   0);
    check({tag, "_dat"},      wb_dat_o,        0);
    check({tag, "_tx_start"}, 32'(tx_start_o), 0);
    check({tag, "_tx_data"},  32'(tx_data_o),  0);
    check({tag, "_rx_clear"}, 32'(rx_clear_o), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c1, c2, c3, n;

    repeat (3) @(posedge clk_i);
    #1 check_outputs_zero("reset");
    rst_i = 1'b0;
    rd_status(IDLE_ST, "status_after_reset");
    rd_data(8'h00, "data_read_empty");

    // Single byte: start pulse carries 0x41; TEMT only after busy falls.
    exp_tx.push_back(8'h41);
    wb_write(A_DATA, 4'h1, 8'h41, c1);
    check("write_ack_latency", 32'(c1), 1);
    rd_status(8'h20, "status_tx_busy");
    wait_tx_drained();
    rd_status(IDLE_ST, "status_tx_done");

    // Back-to-back: second accepted immediately, third stalls on the hold.
    exp_tx.push_back(8'h48);
    exp_tx.push_back(8'h69);
    exp_tx.push_back(8'h0A);
    wb_write(A_DATA, 4'h1, 8'h48, c1);
    wb_write(A_DATA, 4'h1, 8'h69, c2);
    wb_write(A_DATA, 4'h1, 8'h0A, c3);
    check("second_write_ack_latency", 32'(c2), 1);
    check("third_write_stalled", 32'(c3 > 4), 1);
    wait_tx_drained();

    // Ignored writes: no selected lane, and an unmapped offset.
    wb_write(A_DATA, 4'h0, 8'hEE, c1);
    wb_write(3'h2, 4'hF, 8'hEE, c1);
    repeat (4) @(posedge clk_i);
    rd_status(IDLE_ST, "status_after_ignored_writes");
    wb_read(3'h3, 32'h0, "read_unmapped");

    // One received byte.
    rx_deliver(8'h55);
    rd_status(IDLE_ST | 8'h01, "status_one_byte");
    rd_data(8'h55, "data_0x55");
    rd_status(IDLE_ST, "status_drained");
    check("rx_clear_count_single", 32'(clear_cnt), 32'(exp_clear));

    // Overrun: fifth byte is dropped.
    for (int i = 1; i <= 5; i++) rx_deliver(8'(i));
    rd_status(IDLE_ST | 8'h03, "status_overrun");
    for (int i = 1; i <= 4; i++) rd_data(8'(i), "data_overrun_seq");
    rd_data(8'h00, "data_after_drain");
    rd_status(IDLE_ST, "status_overrun_cleared");

    // Full FIFO: pop and push coincide, nothing lost.
    rx_deliver(8'h11);
    rx_deliver(8'h22);
    rx_deliver(8'h33);
    rx_deliver(8'h44);
    fork
      rx_deliver(8'h5A);
      rd_data(8'h11, "data_pop_while_push");
    join
    rd_status(IDLE_ST | 8'h01, "status_no_overrun");
    rd_data(8'h22, "data_full_seq_2");
    rd_data(8'h33, "data_full_seq_3");
    rd_data(8'h44, "data_full_seq_4");
    rd_data(8'h5A, "data_full_seq_5");
    rd_data(8'h00, "data_full_empty");
    check("rx_clear_count", 32'(clear_cnt), 32'(exp_clear));

    // Reset during TX_WAIT and RX_CLEAR.
    exp_tx.push_back(8'hC3);
    wb_write(A_DATA, 4'h1, 8'hC3, c1);
    n = 0;
    while (!tx_busy_i && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("busy_before_reset", 32'(tx_busy_i), 1);
    repeat (3) @(posedge clk_i);
    #1 rx_data_i = 8'h77; rx_ready_i = 1'b1;
    exp_clear++;
    @(posedge clk_i); #1;
    check("rx_clear_before_reset", 32'(rx_clear_o), 1);
    check("tx_data_held", 32'(tx_data_o), 32'h0000_00C3);
    rst_i = 1'b1; rx_ready_i = 1'b0;
    @(posedge clk_i); #1;
    check_outputs_zero("mid_reset");
    rst_i = 1'b0;
    wait_tx_drained();
    rd_status(IDLE_ST, "status_after_mid_reset");
    rd_data(8'h00, "data_after_mid_reset");

    repeat (4) @(posedge clk_i);
    check("rx_clear_count_final", 32'(clear_cnt), 32'(exp_clear));
    check("read_scoreboard_empty", 32'(exp_rd.size()), 0);
    check("tx_scoreboard_empty", 32'(exp_tx.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
